lcd_char_writer: RTL

//  Drives the board's HD44780-compatible character LCD over its 4-bit bus (LCDE/LCDRS/LCDRW/LCDDAT).
//  On power-up it runs the controller init sequence by itself.
//  It then accepts command/data bytes from the debug display logic in mips_top through a valid/ready handshake.
//  It splits each byte into two E-strobed nibbles, enforces all controller timing, and holds off the next byte until the controller is ready.

---
 rtl/lcd_char_writer_pkg.sv | 20 ++
 rtl/lcd_char_writer_timer.sv | 23 ++
 rtl/lcd_char_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lcd_char_writer_pkg.sv
// lcd_char_writer_pkg: shared LCD command bytes, FSM state encoding and small helpers
package lcd_char_writer_pkg;
  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, E_HI, GAP, WAIT} state_e;
  function automatic int maxi(input int a, input int b);
    return a > b ? a : b;
  endfunction
  // Full-byte part of the init sequence, indexed 0..3
  function automatic logic [7:0] init_byte(input logic [1:0] i);
    return i == 2'd0 ? LCD_FUNC_SET : i == 2'd1 ? LCD_ENTRY : i == 2'd2 ? LCD_DISP_ON : LCD_CLEAR;
  endfunction
  // Clear and home need the long controller execution time
  function automatic logic is_slow(input logic rs, input logic [7:0] d);
    return !rs && (d == LCD_CLEAR || d == LCD_HOME);
  endfunction
endpackage

// File: rtl/lcd_char_writer_timer.sv
// lcd_delay_timer: shared down-counter; load N-1 for an N-cycle interval, done when count is 0
//   clk_i   clock
//   rst_ni  async active-low reset, count returns to RST_VAL
//   load_i  load value_i this cycle
//   value_i reload value
//   done_o  count has reached 0
module lcd_delay_timer #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load_i ? value_i : (count_q != '0 ? count_q - 1'b1 : count_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) count_q <= RST_VAL;
    else         count_q <= count_d;
  assign done_o = count_q == '0;
endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: HD44780 4-bit bus writer with self-run init and valid/ready byte input
//   CCLK        system clock
//   rst_n       async active-low reset
//   in_valid/in_ready/in_rs/in_data  byte handshake (rs 0 = command, 1 = data)
//   init_done   init sequence finished, held until reset
//   LCDE/LCDRS/LCDRW/LCDDAT          LCD bus, LCDRW fixed 0
module lcd_char_writer
  import lcd_char_writer_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_E_HIGH  = 12,
  parameter int T_SETUP   = 2,
  parameter int T_GAP     = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic       CCLK,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       LCDE,
  output logic       LCDRS,
  output logic       LCDRW,
  output logic [3:0] LCDDAT
);
  localparam int T_MAX = maxi(maxi(maxi(T_POWERUP, T_INIT1), maxi(T_INIT2, T_E_HIGH)),
                              maxi(maxi(T_SETUP, T_GAP), maxi(T_CMD, T_CLEAR)));
  localparam int W = T_MAX > 1 ? $clog2(T_MAX) : 1;
  typedef logic [W-1:0] cnt_t;
  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] byte_q, byte_d, ib;
  logic       rsb_q, rsb_d, lo_q, lo_d, single_q, single_d, done_q, done_d;
  logic       lcdrs_q, lcdrs_d, e_q, load, tdone;
  logic [3:0] dat_q, dat_d;
  cnt_t       value, wait_val;
  lcd_delay_timer #(.W(W), .RST_VAL(cnt_t'(T_POWERUP - 1))) u_timer (
    .clk_i(CCLK), .rst_ni(rst_n), .load_i(load), .value_i(value), .done_o(tdone)
  );
  // Steps 0..3 are single init nibbles, steps 4..7 the full init bytes
  assign ib = init_byte(step_q[1:0]);
  assign wait_val = single_q ? (step_q == 3'd0 ? cnt_t'(T_INIT1 - 1) :
                                step_q == 3'd1 ? cnt_t'(T_INIT2 - 1) : cnt_t'(T_CMD - 1))
                             : (is_slow(rsb_q, byte_q) ? cnt_t'(T_CLEAR - 1) : cnt_t'(T_CMD - 1));
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    byte_d   = byte_q;
    rsb_d    = rsb_q;
    lo_d     = lo_q;
    single_d = single_q;
    done_d   = done_q;
    lcdrs_d  = lcdrs_q;
    dat_d    = dat_q;
    load     = 1'b0;
    value    = '0;
    case (state_q)
      PWR_WAIT: if (tdone) state_d = INIT;
      INIT: begin
        state_d  = SETUP;
        load     = 1'b1;
        value    = cnt_t'(T_SETUP - 1);
        byte_d   = ib;
        rsb_d    = 1'b0;
        lcdrs_d  = 1'b0;
        lo_d     = 1'b0;
        single_d = !step_q[2];
        dat_d    = step_q[2] ? ib[7:4] : (step_q == 3'd3 ? 4'h2 : 4'h3);
      end
      IDLE: if (in_valid && in_ready) begin
        state_d  = SETUP;
        load     = 1'b1;
        value    = cnt_t'(T_SETUP - 1);
        byte_d   = in_data;
        rsb_d    = in_rs;
        lcdrs_d  = in_rs;
        lo_d     = 1'b0;
        single_d = 1'b0;
        dat_d    = in_data[7:4];
      end
      SETUP: if (tdone) begin
        state_d = E_HI;
        load    = 1'b1;
        value   = cnt_t'(T_E_HIGH - 1);
      end
      E_HI: if (tdone) begin
        state_d = GAP;
        load    = 1'b1;
        value   = cnt_t'(T_GAP - 1);
      end
      GAP: if (tdone) begin
        load    = 1'b1;
        state_d = (!single_q && !lo_q) ? SETUP : WAIT;
        value   = (!single_q && !lo_q) ? cnt_t'(T_SETUP - 1) : wait_val;
        lo_d    = lo_q || !single_q;
        dat_d   = (!single_q && !lo_q) ? byte_q[3:0] : dat_q;
      end
      WAIT: if (tdone) begin
        done_d  = done_q || step_q == 3'd7;
        state_d = done_d ? IDLE : INIT;
        step_d  = done_q ? step_q : step_q + 3'd1;
      end
      default: state_d = PWR_WAIT;
    endcase
  end
  always_ff @(posedge CCLK or negedge rst_n)
    if (!rst_n) begin
      state_q  <= PWR_WAIT;
      step_q   <= '0;
      byte_q   <= '0;
      rsb_q    <= 1'b0;
      lo_q     <= 1'b0;
      single_q <= 1'b0;
      done_q   <= 1'b0;
      lcdrs_q  <= 1'b0;
      dat_q    <= '0;
      e_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      byte_q   <= byte_d;
      rsb_q    <= rsb_d;
      lo_q     <= lo_d;
      single_q <= single_d;
      done_q   <= done_d;
      lcdrs_q  <= lcdrs_d;
      dat_q    <= dat_d;
      e_q      <= state_d == E_HI;
    end
  assign in_ready  = state_q == IDLE && done_q;
  assign init_done = done_q;
  assign LCDE      = e_q;
  assign LCDRS     = lcdrs_q;
  assign LCDDAT    = dat_q;
  assign LCDRW     = 1'b0;
endmodule
